dac_serial_tx: RTL and testbench
================================

DAC_SERIAL_TX -- requirements
Module: dac_serial_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 24, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per sclk half-period, legal range 1..255.
REQ-003 SHALL have parameter GAP_BITS, default 8, idle bit periods appended after each sample, legal range 1..31.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two, legal range 2..16.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  transmit enable, level.
REQ-008 in_sample  input  WIDTH  filtered sample to send.
REQ-009 in_valid  input  1  in_sample valid.
REQ-010 in_ready  output  1  FIFO can accept; equals FIFO not full.
REQ-011 sclk  output  1  serial bit clock.
REQ-012 sdata  output  1  serial data, MSB first.
REQ-013 fs  output  1  frame sync, high during the MSB bit period only.
REQ-014 underflow  output  1  one-clk pulse when a frame starts with the FIFO empty.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL accept a sample on each rising clk edge where in_valid and in_ready are both high; in_valid without in_ready SHALL be ignored, with no loss of FIFO contents.
REQ-017 Bit period SHALL be 2*CLK_DIV clk cycles: sclk low in the first half, high in the second; sdata and fs SHALL change only at bit-period start.
REQ-018 FSM states SHALL be IDLE, LOAD, SHIFT, GAP.
REQ-019 IDLE->LOAD when en=1 and FIFO not empty; in IDLE sclk=0, sdata=0, fs=0.
REQ-020 LOAD SHALL last exactly one clk, pop the FIFO head into the shift register, then go to SHIFT.
REQ-021 SHIFT SHALL last WIDTH bit periods, sending bit WIDTH-1 down to bit 0; then go to GAP.
REQ-022 GAP SHALL last GAP_BITS bit periods with sdata=0 and sclk toggling; at its end: en=1 -> LOAD; en=0 -> IDLE.
REQ-023 LOAD with FIFO empty (only reachable from GAP) SHALL pulse underflow and load the underflow value (REQ-030/031).
REQ-024 A sample accepted at edge k into an empty FIFO while in IDLE with en=1 SHALL put its MSB on sdata with fs=1 after edge k+2.
REQ-025 Deasserting en mid-frame SHALL NOT truncate the frame; the current SHIFT and GAP complete.
REQ-026 Simultaneous push and pop SHALL be allowed; pop sees the pre-push state, so push into an empty FIFO during LOAD still raises underflow.
REQ-027 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-028 While rst_n=0: state IDLE, FIFO empty, in_ready=1, sclk=0, sdata=0, fs=0, underflow=0, busy=0, all counters 0.
REQ-029 Reset asserted mid-frame SHALL abort immediately; after release, no partial frame SHALL be resumed and FIFO contents SHALL be discarded.

Configuration
REQ-030 With macro DAC_SERIAL_TX_HOLD_EN defined, underflow SHALL retransmit the last loaded sample (0 if none since reset).
REQ-031 Without DAC_SERIAL_TX_HOLD_EN, underflow SHALL transmit all zeros.

Structure
REQ-032 Shared package dac_tx_pkg SHALL hold the FSM state encoding and the default WIDTH/CLK_DIV/GAP_BITS/FIFO_DEPTH constants.
REQ-033 FIFO SHALL be a separate sub-module sample_fifo (WIDTH x FIFO_DEPTH, synchronous, show-ahead).

Verification
REQ-034 Reset with defaults, push 24'h800001 with en=1 -> fs=1 for one bit period, sdata bits 1,0x22,1 MSB-first, 24 bit periods then 8 zero bits.
REQ-035 en held 1, push 4 samples back-to-back -> in_ready low after 4th until first LOAD; 4 contiguous 32-bit-period frames, no underflow.
REQ-036 en=1, one sample 24'h123456 then none -> second frame raises underflow once; sends 24'h000000, or 24'h123456 with DAC_SERIAL_TX_HOLD_EN.
REQ-037 Drop en at bit 5 of SHIFT -> frame completes incl. GAP, then IDLE with busy=0, sclk=0.
REQ-038 Assert rst_n=0 at bit 10 of SHIFT with 3 samples queued -> outputs at reset values at once; after release, in_ready=1, no frame until new push.
REQ-039 CLK_DIV=1 -> sclk period 2 clk, frame 64 clk for defaults.

Source files
------------

// File: rtl/dac_tx_pkg.sv
// Shared constants for the serial DAC transmitter: default geometry and FSM state encoding.
package dac_tx_pkg;

  localparam int DEF_WIDTH      = 24;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_GAP_BITS   = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

endpackage

// File: rtl/dac_serial_tx_if.sv
// Sample input handshake of the serial DAC transmitter (valid/ready, ready = FIFO not full).
interface dac_serial_tx_if
  import dac_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] in_sample;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_sample, output in_valid, input  in_ready);
  modport slave  (input  in_sample, input  in_valid, output in_ready);

endinterface

// File: rtl/sample_fifo.sv
// Show-ahead sample FIFO; pointers carry one extra wrap bit to tell full from empty.
module sample_fifo
  import dac_tx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: always_comb uses blocking '=' and assigns every output on every path, so no latch can form.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  // NOTE: flops use non-blocking '<=' so every update samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; equal pointers already mark every entry as invalid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dac_serial_tx.sv
// Serial DAC transmitter: FIFO-buffered samples sent MSB first with sclk/fs and an idle gap.
// Define DAC_SERIAL_TX_HOLD_EN to repeat the last loaded sample on underflow instead of zeros.
module dac_serial_tx
  import dac_tx_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int GAP_BITS   = DEF_GAP_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  dac_serial_tx_if.slave  in_if,
  output logic            sclk,
  output logic            sdata,
  output logic            fs,
  output logic            underflow,
  output logic            busy
);

  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam int BC_W = $clog2(((WIDTH > GAP_BITS) ? WIDTH : GAP_BITS) + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV);

  logic [1:0]       state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [BC_W-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             sdata_q, sdata_d;
  logic             fs_q, fs_d;
  logic             sclk_q, sclk_d;
  logic             underflow_q, underflow_d;
  logic             bit_end;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic [WIDTH-1:0] uf_value;

  sample_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_if.in_valid),
    .push_data (in_if.in_sample),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_if.in_ready = !fifo_full;

`ifdef DAC_SERIAL_TX_HOLD_EN
  logic [WIDTH-1:0] last_q, last_d;
  assign last_d   = (state_q == ST_LOAD) ? shift_d : last_q;
  assign uf_value = last_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= '0;
    else        last_q <= last_d;
  end
`else
  assign uf_value = '0;
`endif

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    sdata_d     = sdata_q;
    fs_d        = fs_q;
    underflow_d = 1'b0;
    fifo_pop    = 1'b0;
    bit_end     = (ph_q == PH_LAST);
    case (state_q)
      ST_IDLE: begin
        ph_d    = '0;
        bit_d   = '0;
        sdata_d = 1'b0;
        fs_d    = 1'b0;
        if (en && !fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // The pop decision sees the FIFO before any same-edge push lands.
        fifo_pop    = !fifo_empty;
        underflow_d = fifo_empty;
        shift_d     = fifo_empty ? uf_value : fifo_head;
        sdata_d     = shift_d[WIDTH-1];
        fs_d        = 1'b1;
        ph_d        = '0;
        bit_d       = '0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        ph_d = bit_end ? '0 : ph_q + 1'b1;
        if (bit_end) begin
          fs_d = 1'b0;
          if (bit_q == BC_W'(WIDTH - 1)) begin
            state_d = ST_GAP;
            bit_d   = '0;
            sdata_d = 1'b0;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q << 1;
            sdata_d = shift_d[WIDTH-1];
          end
        end
      end
      ST_GAP: begin
        ph_d = bit_end ? '0 : ph_q + 1'b1;
        if (bit_end) begin
          if (bit_q == BC_W'(GAP_BITS - 1)) begin
            bit_d   = '0;
            state_d = en ? ST_LOAD : ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // sclk is registered from the next phase so it is glitch-free and aligned with sdata.
    sclk_d = ((state_d == ST_SHIFT) || (state_d == ST_GAP)) && (ph_d >= PH_HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      sdata_q     <= 1'b0;
      fs_q        <= 1'b0;
      sclk_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      sdata_q     <= sdata_d;
      fs_q        <= fs_d;
      sclk_q      <= sclk_d;
      underflow_q <= underflow_d;
    end
  end

  assign sclk      = sclk_q;
  assign sdata     = sdata_q;
  assign fs        = fs_q;
  assign underflow = underflow_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx: default instance plus a CLK_DIV=1 instance.
module tb_dac_serial_tx;

  logic clk = 1'b0;
  logic rst_n, en, en_f;
  logic sclk, sdata, fs, underflow, busy;
  logic sclk_f, sdata_f, fs_f, underflow_f, busy_f;

  int checks   = 0;
  int failures = 0;

  // Per-frame observations filled by run_frame.
  logic [23:0] fr_word;
  int fr_fs, fr_rises, fr_gap_ones, fr_glitches, fr_uf;
  logic [23:0] push_vals [4];
  bit found;

`ifdef DAC_SERIAL_TX_HOLD_EN
  localparam logic [23:0] UF_EXP = 24'h123456;
`else
  localparam logic [23:0] UF_EXP = 24'h000000;
`endif

  dac_serial_tx_if bus   ();
  dac_serial_tx_if bus_f ();

  always #5 clk = ~clk;

  dac_serial_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_if     (bus),
    .sclk      (sclk),
    .sdata     (sdata),
    .fs        (fs),
    .underflow (underflow),
    .busy      (busy)
  );

  dac_serial_tx #(.CLK_DIV(1)) dut_fast (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_f),
    .in_if     (bus_f),
    .sclk      (sclk_f),
    .sdata     (sdata_f),
    .fs        (fs_f),
    .underflow (underflow_f),
    .busy      (busy_f)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (fs === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("fs_wait", {31'd0, ok}, 32'd1);
  endtask

  // Called on the first cycle of bit 0; returns on the cycle after the gap ends.
  task automatic run_frame(input int drop_bit, input bit push4);
    logic prev_sclk, prev_sdata, prev_fs;
    fr_word = '0; fr_fs = 0; fr_rises = 0; fr_gap_ones = 0; fr_glitches = 0; fr_uf = 0;
    prev_sclk = 1'b0; prev_sdata = sdata; prev_fs = fs;
    for (int c = 0; c < 256; c++) begin
      if (c % 8 == 0) begin
        if (c < 192) fr_word[23 - c / 8] = sdata;
      end else if (sdata !== prev_sdata || fs !== prev_fs) begin
        fr_glitches++;
      end
      if (fs === 1'b1) fr_fs++;
      if (sclk === 1'b1 && prev_sclk === 1'b0) fr_rises++;
      if (c >= 192 && sdata !== 1'b0) fr_gap_ones++;
      if (underflow === 1'b1) fr_uf++;
      prev_sclk = sclk; prev_sdata = sdata; prev_fs = fs;
      if (drop_bit >= 0 && c == drop_bit * 8) en = 1'b0;
      if (push4) begin
        if (c < 4) begin
          bus.in_valid  = 1'b1;
          bus.in_sample = push_vals[c];
        end else if (c == 4) begin
          check("ready_low_after_4th", {31'd0, bus.in_ready}, 32'd0);
          bus.in_sample = 24'hDEAD00;
        end else if (c == 250) begin
          bus.in_valid = 1'b0;
        end else if (c == 255) begin
          check("ready_low_before_load", {31'd0, bus.in_ready}, 32'd0);
        end
      end
      tick();
    end
  endtask

  task automatic check_frame(input string tag, input logic [23:0] exp_word, input int exp_uf);
    check({tag, "_word"}, {8'd0, fr_word}, {8'd0, exp_word});
    check({tag, "_fs_cycles"}, fr_fs, 32'd8);
    check({tag, "_sclk_rises"}, fr_rises, 32'd32);
    check({tag, "_gap_zero"}, fr_gap_ones, 32'd0);
    check({tag, "_mid_bit_change"}, fr_glitches, 32'd0);
    check({tag, "_underflow"}, fr_uf, exp_uf);
  endtask

  initial begin
    int busy_seen, rises, busy_cnt;
    logic prev;
    logic [23:0] w;
    logic s0, s1;

    rst_n = 1'b0; en = 1'b0; en_f = 1'b0;
    bus.in_valid = 1'b0;   bus.in_sample = '0;
    bus_f.in_valid = 1'b0; bus_f.in_sample = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_sdata", {31'd0, sdata}, 32'd0);
    check("rst_fs", {31'd0, fs}, 32'd0);
    check("rst_underflow", {31'd0, underflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single sample 800001, start latency k+2, en dropped at bit 5.
    en = 1'b1;
    bus.in_valid = 1'b1; bus.in_sample = 24'h800001;
    tick();
    bus.in_valid = 1'b0;
    check("lat_k_busy", {31'd0, busy}, 32'd0);
    check("lat_k_fs", {31'd0, fs}, 32'd0);
    tick();
    check("lat_k1_busy", {31'd0, busy}, 32'd1);
    check("lat_k1_fs", {31'd0, fs}, 32'd0);
    tick();
    check("lat_k2_fs", {31'd0, fs}, 32'd1);
    check("lat_k2_sdata", {31'd0, sdata}, 32'd1);
    check("lat_k2_sclk", {31'd0, sclk}, 32'd0);
    run_frame(5, 1'b0);
    check_frame("f800001", 24'h800001, 0);
    check("drop_en_busy", {31'd0, busy}, 32'd0);
    check("drop_en_sclk", {31'd0, sclk}, 32'd0);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1) busy_seen++;
      tick();
    end
    check("idle_stays", busy_seen, 32'd0);

    // Frame in flight plus four back-to-back pushes fill the FIFO.
    push_vals[0] = 24'h111111; push_vals[1] = 24'hA5A5A5;
    push_vals[2] = 24'h5A5A5A; push_vals[3] = 24'hFFFFFE;
    en = 1'b1;
    bus.in_valid = 1'b1; bus.in_sample = 24'h0000FF;
    tick();
    bus.in_valid = 1'b0;
    wait_fs(20, found);
    run_frame(-1, 1'b1);
    check_frame("fs0", 24'h0000FF, 0);
    check("load_ready_low", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("contig_fs", {31'd0, fs}, 32'd1);
      if (i == 0) check("ready_after_load", {31'd0, bus.in_ready}, 32'd1);
      run_frame((i == 3) ? 5 : -1, 1'b0);
      check_frame("queued", push_vals[i], 0);
    end
    check("queued_end_busy", {31'd0, busy}, 32'd0);

    // Underflow on second frame; push lands during the underflowing LOAD.
    en = 1'b1;
    bus.in_valid = 1'b1; bus.in_sample = 24'h123456;
    tick();
    bus.in_valid = 1'b0;
    wait_fs(20, found);
    run_frame(-1, 1'b0);
    check_frame("f123456", 24'h123456, 0);
    check("uf_load_busy", {31'd0, busy}, 32'd1);
    bus.in_valid = 1'b1; bus.in_sample = 24'h0F0F0F;
    tick();
    bus.in_valid = 1'b0;
    check("uf_pulse", {31'd0, underflow}, 32'd1);
    check("uf_fs", {31'd0, fs}, 32'd1);
    run_frame(5, 1'b0);
    check_frame("funder", UF_EXP, 1);
    check("uf_end_busy", {31'd0, busy}, 32'd0);

    // Abort by reset at bit 10 with three samples queued.
    en = 1'b1;
    bus.in_valid = 1'b1; bus.in_sample = 24'h222222;
    tick();
    bus.in_sample = 24'h333333;
    tick();
    check("late_push_frame_fs", {31'd0, fs}, 32'd1);
    check("late_push_frame_msb", {31'd0, sdata}, 32'd0);
    bus.in_sample = 24'h444444;
    tick();
    bus.in_valid = 1'b0;
    check("queued_three_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (79) tick();
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sclk", {31'd0, sclk}, 32'd0);
    check("abort_sdata", {31'd0, sdata}, 32'd0);
    check("abort_fs", {31'd0, fs}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1 || fs === 1'b1) busy_seen++;
      tick();
    end
    check("no_resume", busy_seen, 32'd0);
    bus.in_valid = 1'b1; bus.in_sample = 24'h7FFFFF;
    tick();
    bus.in_valid = 1'b0;
    wait_fs(20, found);
    run_frame(5, 1'b0);
    check_frame("f7fffff", 24'h7FFFFF, 0);

    // CLK_DIV=1: two-clk sclk period, 64-clk shift+gap.
    en_f = 1'b1;
    bus_f.in_valid = 1'b1; bus_f.in_sample = 24'hC00003;
    tick();
    bus_f.in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fs_f === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("fast_fs_wait", {31'd0, found}, 32'd1);
    en_f = 1'b0;
    busy_cnt = 0; rises = 0; prev = 1'b0; w = '0; s0 = 1'bx; s1 = 1'bx;
    for (int c = 0; c < 100; c++) begin
      if (c == 0) s0 = sclk_f;
      if (c == 1) s1 = sclk_f;
      if (c < 48 && c % 2 == 0) w[23 - c / 2] = sdata_f;
      if (busy_f === 1'b1) busy_cnt++;
      if (sclk_f === 1'b1 && prev === 1'b0) rises++;
      prev = sclk_f;
      tick();
    end
    check("fast_sclk_lo", {31'd0, s0}, 32'd0);
    check("fast_sclk_hi", {31'd0, s1}, 32'd1);
    check("fast_word", {8'd0, w}, 32'h00C00003);
    check("fast_frame_clks", busy_cnt, 32'd64);
    check("fast_sclk_rises", rises, 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
